// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of the shared 8-bit tri-state bus.
// Registered one-hot grants, fixed dead-bus gap, optional hold limit.
module bus_arbiter #(
  parameter int N_REQ      = 4,
  parameter int MAX_HOLD   = 16,
  parameter int TURNAROUND = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic                     timeout
);

  localparam int IW = $clog2(N_REQ);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int TW = $clog2(TURNAROUND + 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [HW-1:0] hcnt;
  logic [TW-1:0] tcnt;

  logic [IW-1:0]    pick;
  logic             any_req;
  logic [N_REQ-1:0] others;
  logic             own_req;
  logic             hold_hit;
  logic             forced;
  logic             release_now;
  logic [IW-1:0]    ptr_next;

  // First asserted request searching ptr, ptr+1, ... modulo N_REQ
  always_comb begin
    pick    = ptr;
    any_req = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (req[j] && j == (int'(ptr) + i) % N_REQ) begin
          pick    = IW'(j);
          any_req = 1'b1;
        end
      end
    end
  end

  // Release conditions for the current owner
  always_comb begin
    others      = req & ~(N_REQ'(1) << owner);
    own_req     = req[owner];
    hold_hit    = (MAX_HOLD != 0) && (hcnt == HW'(MAX_HOLD));
    forced      = own_req && hold_hit && (|others);
    release_now = !own_req || forced;
    ptr_next    = (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);
  end

  // Arbitration FSM; every output is a flop
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      owner   <= '0;
      ptr     <= '0;
      hcnt    <= '0;
      tcnt    <= '0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            gnt   <= N_REQ'(1) << pick;
            busy  <= 1'b1;
            owner <= pick;
            hcnt  <= HW'(1);
            state <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            gnt     <= '0;
            busy    <= 1'b0;
            ptr     <= ptr_next;
            tcnt    <= TW'(TURNAROUND);
            timeout <= forced;
            state   <= TURN;
          end else if (MAX_HOLD != 0 && !hold_hit) begin
            hcnt <= hcnt + HW'(1);
          end
        end
        TURN: begin
          if (tcnt == TW'(1)) begin
            if (any_req) begin
              gnt   <= N_REQ'(1) << pick;
              busy  <= 1'b1;
              owner <= pick;
              hcnt  <= HW'(1);
              state <= GRANT;
            end else begin
              state <= IDLE;
            end
          end else begin
            tcnt <= tcnt - TW'(1);
          end
        end
        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: three arbiter configurations on shared stimulus,
// each compared every cycle with a rule-level reference model.
module tb_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;

  logic [3:0] gnt_a, gnt_b, gnt_c;
  logic [1:0] own_a, own_b, own_c;
  logic       busy_a, busy_b, busy_c;
  logic       to_a, to_b, to_c;

  bus_arbiter #(.N_REQ(4), .MAX_HOLD(4), .TURNAROUND(1)) dut_a (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt_a),
    .owner(own_a), .busy(busy_a), .timeout(to_a)
  );

  bus_arbiter #(.N_REQ(4), .MAX_HOLD(16), .TURNAROUND(1)) dut_b (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt_b),
    .owner(own_b), .busy(busy_b), .timeout(to_b)
  );

  bus_arbiter #(.N_REQ(4), .MAX_HOLD(16), .TURNAROUND(2)) dut_c (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt_c),
    .owner(own_c), .busy(busy_c), .timeout(to_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] obs [3];
  always_comb begin
    obs[0] = {gnt_a, own_a, busy_a, to_a};
    obs[1] = {gnt_b, own_b, busy_b, to_b};
    obs[2] = {gnt_c, own_c, busy_c, to_c};
  end

  int n_chk;
  int n_pass;

  // reference model state, one slot per DUT
  int cur  [3];
  int last [3];
  int ptr  [3];
  int held [3];
  int gap  [3];
  bit tmo  [3];

  function automatic int mh(input int d);
    return (d == 0) ? 4 : 16;
  endfunction

  function automatic int ta(input int d);
    return (d == 2) ? 2 : 1;
  endfunction

  function automatic logic [7:0] expv(input int d);
    logic [3:0] g;
    g = (cur[d] >= 0) ? 4'(1 << cur[d]) : 4'b0000;
    return {g, 2'(last[d]), cur[d] >= 0, tmo[d]};
  endfunction

  task automatic model_step(input int d, input logic r,
                            input logic [3:0] q);
    int oth;
    if (r) begin
      cur[d] = -1; last[d] = 0; ptr[d] = 0;
      held[d] = 0; gap[d] = 0; tmo[d] = 0;
      return;
    end
    tmo[d] = 0;
    if (cur[d] >= 0) begin
      oth = int'(q) & ~(1 << cur[d]);
      if (!q[cur[d]] ||
          (mh(d) > 0 && held[d] >= mh(d) && oth != 0)) begin
        tmo[d] = q[cur[d]];
        ptr[d] = (cur[d] + 1) % 4;
        cur[d] = -1;
        gap[d] = ta(d);
      end else begin
        held[d]++;
      end
    end else if (gap[d] > 1) begin
      gap[d]--;
    end else begin
      gap[d] = 0;
      for (int i = 0; i < 4; i++) begin
        if (q[(ptr[d] + i) % 4]) begin
          cur[d] = (ptr[d] + i) % 4;
          break;
        end
      end
      if (cur[d] >= 0) begin
        last[d] = cur[d];
        held[d] = 1;
      end
    end
  endtask

  task automatic tick(input logic r, input logic [3:0] q);
    @(negedge clk);
    rst = r;
    req = q;
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_step(d, r, q);
    #1;
  endtask

  task automatic test_reset;
    for (int c = 0; c < 3; c++) begin
      tick(c < 2, 4'b1111);
      for (int d = 0; d < 3; d++) begin
        n_chk++;
        if (obs[d] !== expv(d))
          $display("FAIL reset dut%0d cyc%0d got %b want %b",
                   d, c, obs[d], expv(d));
        else n_pass++;
      end
    end
    n_chk++;
    if (gnt_b !== 4'b0001)
      $display("FAIL reset_first_gnt got %b want 0001", gnt_b);
    else n_pass++;
    for (int c = 0; c < 4; c++) tick(1'b0, 4'b0000);
  endtask

  task automatic test_single;
    for (int c = 0; c < 12; c++) begin
      tick(1'b0, (c < 6) ? 4'b0100 : 4'b0000);
      for (int d = 0; d < 3; d++) begin
        n_chk++;
        if (obs[d] !== expv(d))
          $display("FAIL single dut%0d cyc%0d got %b want %b",
                   d, c, obs[d], expv(d));
        else n_pass++;
      end
    end
    n_chk++;
    if (own_b !== 2'd2 || gnt_b !== 4'b0000)
      $display("FAIL single_owner_kept got %0d/%b want 2/0000",
               own_b, gnt_b);
    else n_pass++;
  endtask

  task automatic test_round_robin;
    int pulses;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      tick(1'b0, 4'b1111);
      pulses += int'(to_a);
      for (int d = 0; d < 3; d++) begin
        n_chk++;
        if (obs[d] !== expv(d))
          $display("FAIL rr dut%0d cyc%0d got %b want %b",
                   d, c, obs[d], expv(d));
        else n_pass++;
      end
    end
    n_chk++;
    if (pulses < 4)
      $display("FAIL rr_timeouts got %0d want >=4", pulses);
    else n_pass++;
    for (int c = 0; c < 4; c++) tick(1'b0, 4'b0000);
  endtask

  task automatic test_turnaround;
    logic [3:0] q;
    for (int c = 0; c < 10; c++) begin
      q = (c < 2) ? 4'b0001 : (c < 4) ? 4'b1001 : 4'b1000;
      tick(1'b0, q);
      for (int d = 0; d < 3; d++) begin
        n_chk++;
        if (obs[d] !== expv(d))
          $display("FAIL turn dut%0d cyc%0d got %b want %b",
                   d, c, obs[d], expv(d));
        else n_pass++;
      end
    end
    n_chk++;
    if (gnt_c !== 4'b1000 || own_c !== 2'd3)
      $display("FAIL turn_owner3 got %b/%0d want 1000/3",
               gnt_c, own_c);
    else n_pass++;
    for (int c = 0; c < 4; c++) tick(1'b0, 4'b0000);
  endtask

  task automatic test_no_preempt;
    for (int c = 0; c < 52; c++) begin
      tick(1'b0, (c < 41) ? 4'b0010 :
                 (c < 48) ? 4'b1010 : 4'b0000);
      for (int d = 0; d < 3; d++) begin
        n_chk++;
        if (obs[d] !== expv(d))
          $display("FAIL nopre dut%0d cyc%0d got %b want %b",
                   d, c, obs[d], expv(d));
        else n_pass++;
      end
      if (c == 40) begin
        n_chk++;
        if (gnt_b !== 4'b0010 || to_b !== 1'b0)
          $display("FAIL nopre_hold got %b/%b want 0010/0",
                   gnt_b, to_b);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid;
    for (int c = 0; c < 3; c++) tick(1'b0, 4'b0100);
    n_chk++;
    if (gnt_b !== 4'b0100)
      $display("FAIL rstmid_pre got %b want 0100", gnt_b);
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      tick(c == 0, 4'b1010);
      for (int d = 0; d < 3; d++) begin
        n_chk++;
        if (obs[d] !== expv(d))
          $display("FAIL rstmid dut%0d cyc%0d got %b want %b",
                   d, c, obs[d], expv(d));
        else n_pass++;
      end
      if (c == 1) begin
        n_chk++;
        if (gnt_b !== 4'b0010)
          $display("FAIL rstmid_regrant got %b want 0010", gnt_b);
        else n_pass++;
      end
    end
    for (int c = 0; c < 4; c++) tick(1'b0, 4'b0000);
  endtask

  task automatic test_drop_at_limit;
    bit done;
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (cur[0] >= 0 && held[0] == mh(0)) begin
        tick(1'b0, 4'b0011 & ~(4'b0001 << cur[0]));
        done = 1;
        n_chk++;
        if (to_a !== 1'b0 || gnt_a !== 4'b0000)
          $display("FAIL droplim got to=%b gnt=%b want 0/0000",
                   to_a, gnt_a);
        else n_pass++;
      end else begin
        tick(1'b0, 4'b0011);
      end
      for (int d = 0; d < 3; d++) begin
        n_chk++;
        if (obs[d] !== expv(d))
          $display("FAIL droplim dut%0d cyc%0d got %b want %b",
                   d, c, obs[d], expv(d));
        else n_pass++;
      end
    end
    n_chk++;
    if (!done) $display("FAIL droplim_reach got 0 want 1");
    else n_pass++;
    for (int c = 0; c < 4; c++) tick(1'b0, 4'b0000);
  endtask

  task automatic test_random;
    logic [3:0] q;
    logic       r;
    q = 4'b0000;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) q = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 63) == 0);
      tick(r, q);
      for (int d = 0; d < 3; d++) begin
        n_chk++;
        if (obs[d] !== expv(d))
          $display("FAIL rand dut%0d cyc%0d got %b want %b",
                   d, c, obs[d], expv(d));
        else n_pass++;
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    req    = 4'b0000;
    for (int d = 0; d < 3; d++) begin
      cur[d] = -1; last[d] = 0; ptr[d] = 0;
      held[d] = 0; gap[d] = 0; tmo[d] = 0;
    end
    test_reset;
    test_single;
    test_round_robin;
    test_turnaround;
    test_no_preempt;
    test_reset_mid;
    test_drop_at_limit;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
